// File: rtl/aes_spi_pkg.sv
// Shared definitions for the serial AES front-end.
// Holds the FSM state encoding, counter and block widths, and the frame length helper.
package aes_spi_pkg;

    localparam int unsigned CNT_W   = 9;
    localparam int unsigned BLOCK_W = 128;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RX   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_TX   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Bits in one frame: key field followed by one plaintext block.
    function automatic int unsigned frame_bits(input int unsigned nk);
        return nk * 32 + BLOCK_W;
    endfunction

endpackage

// File: rtl/aes_tx_shifter.sv
// Ciphertext output shifter.
// 128-bit left shift register; its MSB flop drives the serial output directly.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       capture data (takes effect on the same edge, MSB visible after it)
//   shift      shift left by one, zero fill
//   clear      zero the register (highest priority)
//   data       parallel ciphertext
//   mosi       serial output, MSB first
module aes_tx_shifter
    import aes_spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic               clear,
    input  logic [BLOCK_W-1:0] data,
    output logic               mosi
);

    logic [BLOCK_W-1:0] tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
        end else if (clear) begin
            tx_q <= '0;
        end else if (load) begin
            tx_q <= data;
        end else if (shift) begin
            tx_q <= {tx_q[BLOCK_W-2:0], 1'b0};
        end
    end

    assign mosi = tx_q[BLOCK_W-1];

endmodule

// File: rtl/aes_spi_frame_link.sv
// Serial front-end for the AES encryption core.
// Receives key then plaintext MSB-first while cs is low, presents them in parallel,
// waits LATENCY edges, captures the ciphertext and shifts it back out MSB-first.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   cs         active-low frame select
//   miso       serial data in (key, then plaintext)
//   key, in    last fully received key and plaintext
//   cipher     ciphertext from the core
//   mosi       serial ciphertext out
//   busy       frame in progress
//   done       one-cycle pulse on the edge retiring the last ciphertext bit
module aes_spi_frame_link
    import aes_spi_pkg::*;
#(
    parameter int unsigned Nk      = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               miso,
    output logic [Nk*32-1:0]   key,
    output logic [BLOCK_W-1:0] in,
    input  logic [BLOCK_W-1:0] cipher,
    output logic               mosi,
    output logic               busy,
    output logic               done
);

    localparam int unsigned FRAME = frame_bits(Nk);

    localparam logic [CNT_W-1:0] LAST_RX  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(BLOCK_W - 1);

    logic [2:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [FRAME-2:0] rx_q;
    logic [FRAME-1:0] rx_next;
    logic             tx_load;
    logic             tx_shift;
    logic             tx_clear;

    // Includes the bit being sampled this edge, so the last bit lands straight in key/in.
    assign rx_next = {rx_q, miso};

    always_comb begin
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        tx_clear = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cs) begin
                    tx_clear = 1'b1;
                end else if (cnt_q == LAST_LAT) begin
                    tx_load = 1'b1;
                end
            end
            ST_TX: begin
                if (cs || cnt_q == LAST_TX) begin
                    tx_clear = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            key     <= '0;
            in      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!cs) begin
                        rx_q    <= rx_next[FRAME-2:0];
                        cnt_q   <= CNT_W'(1);
                        busy    <= 1'b1;
                        state_q <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (cs) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        rx_q <= rx_next[FRAME-2:0];
                        if (cnt_q == LAST_RX) begin
                            key     <= rx_next[FRAME-1:BLOCK_W];
                            in      <= rx_next[BLOCK_W-1:0];
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cs) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else if (cnt_q == LAST_LAT) begin
                        cnt_q   <= '0;
                        state_q <= ST_TX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TX: begin
                    if (cs) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else if (cnt_q == LAST_TX) begin
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (cs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    aes_tx_shifter u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .shift (tx_shift),
        .clear (tx_clear),
        .data  (cipher),
        .mosi  (mosi)
    );

endmodule

// File: doc/aes_spi_frame_link.md
Name: aes_spi_frame_link

Overview:
- Serial front-end feeding the AES-128/192/256 encryption datapath.
- Deserialises a key and a 128-bit plaintext block from a single-wire input framed by an active-low chip select.
- Presents both to the cipher core as stable parallel words, waits a programmable settle/latency time, captures the ciphertext and serialises it back out MSB-first.
- Replaces the ad-hoc serial glue in front of the encryption core; same frame convention.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); key field is Nk*32 bits.
- LATENCY, 1, clk cycles between parallel outputs updating and ciphertext capture; range 1..15.

Ports:
- clk  input  1  single clock; serial clock, all sampling on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  active-low frame select.
- miso  input  1  serial data in, MSB first: key, then plaintext.
- key  output  Nk*32  last fully received key.
- in  output  128  last fully received plaintext.
- cipher  input  128  ciphertext from encryption core.
- mosi  output  1  serial ciphertext out, MSB first.
- busy  output  1  high from first sampled bit until ciphertext fully shifted.
- done  output  1  one-cycle pulse on edge that shifts the last ciphertext bit.

Behaviour:
- Reset (async assert, sync release): key=0, in=0, mosi=0, busy=0, done=0, state IDLE, counters=0, shift registers=0.
- States: IDLE, RX, WAIT, TX, DONE.
  - FRAME = Nk*32+128 bits; 9-bit bit counter (max 384).
- IDLE, cs=0 at rising edge:
  - Sample miso into rx shift register (shift left, LSB in).
  - cnt=1, busy=1, go RX.
- RX, cs=0:
  - Shift one bit per edge.
  - On the edge sampling bit FRAME-1, load key = rx[FRAME-1:128] and in = rx[127:0] in parallel, including that bit.
  - Go WAIT, wait counter=0.
- key/in change only at that edge; they hold otherwise, including across aborts and the whole TX phase.
- WAIT:
  - Count LATENCY edges.
  - On the LATENCY-th edge after the key/in load, load tx register with cipher.
  - Drive mosi = cipher[127] from the same edge; go TX, cnt=0.
- TX:
  - Each edge shift tx left; mosi = tx MSB (registered output, no combinational path from cipher).
  - Bit i of ciphertext (i=0 is bit 127) is valid on mosi for the cycle after edge LATENCY+i following the load.
  - The edge that retires bit 0: mosi=0, done=1 for one cycle, busy=0, go DONE.
- DONE: miso ignored, mosi=0; on cs=1 go IDLE.
- Abort: cs=1 sampled in RX, WAIT or TX → IDLE next edge.
  - mosi=0, busy=0, done not pulsed, counters cleared.
  - key/in keep last completed values (an abort in WAIT/TX keeps the new values).
- A bit is sampled only on edges where cs=0; the cs=0 edge that leaves IDLE counts as bit 0.
- Back-to-back frames: from DONE, cs must return high for ≥1 edge before the next frame.
- rst mid-frame: immediate return to reset values regardless of cs.

Decomposition:
- Package aes_spi_pkg:
  - state encoding (5 states, 3-bit);
  - function frame_bits(Nk) = Nk*32+128;
  - CNT_W = 9;
  - BLOCK_W = 128.
- One sub-module, aes_tx_shifter: 128-bit parallel-load left shift register with registered serial MSB, load/shift/clear inputs.
- RX shifting and the FSM stay in the top module.

Test Plan:
- FIPS-197 AES-128 frame: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, 256 edges with cs=0.
  - key and in equal those values right after edge 256; busy rose on edge 1.
- Same frame, cipher tied to 69c4e0d86a7b0430d8cdb78070b4c55a, LATENCY=1.
  - mosi yields 0,1,1,0,1,0,0,1… (0x69 first).
  - All 128 bits reassemble to 69c4…c55a.
  - done pulses once, then mosi=0.
- Abort: valid frame A, then frame B with cs raised after 100 bits.
  - key/in still hold A.
  - After cs high, new full frame B loads correctly.
- Async rst asserted mid-TX (bit 40), no clock edge.
  - mosi, busy, key, in go 0 immediately.
  - After release, new frame works.
- LATENCY=4 with cipher changed 2 cycles after key/in load.
  - Captured value is the value present at the 4th edge.
  - First mosi bit appears 4 edges after the load.
- Nk=8, 384-bit frame, key 000102…1f.
  - key loads only after edge 384; in correct.
  - Ciphertext returned intact.
